// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH steps per division.
// Divide-by-zero short-circuits straight to DONE with quotient all ones and remainder = a.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh, rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             ge;

  // One restoring step; the working remainder never exceeds WIDTH+1 bits.
  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_nx = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    quo_nx = {quo_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvd_d = a;
          dvs_d = b;
          rem_d = '0;
          quo_d = '0;
          cnt_d = '0;
          if (b == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rmd_d   = a;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          quot_d  = quo_nx;
          rmd_d   = rem_nx[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      quot_q  <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized checks of seq_divider against a plain a/b, a%b reference.
module tb_seq_divider;
  localparam int W = 4;

  logic         clk, rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;

  // Last completed result, as the reference model sees it.
  logic [W-1:0] exp_q = '0, exp_r = '0;
  logic         exp_z = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi);
    if (bi == 0) begin
      exp_q = '1; exp_r = ai; exp_z = 1'b1;
    end else begin
      exp_q = W'(int'(ai) / int'(bi));
      exp_r = W'(int'(ai) % int'(bi));
      exp_z = 1'b0;
    end
  endtask

  // Sample point is #1 after a rising edge; runs until done or the cycle budget expires.
  task automatic wait_done(input bit scramble, output int nbusy);
    bit got;
    nbusy = 0;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) begin
        nbusy++;
        chk("hold_q", quotient, exp_q);
        chk("hold_r", remainder, exp_r);
        chk("hold_z", div_by_zero, exp_z);
      end
      if (scramble) begin
        a = W'($urandom_range(0, (1 << W) - 1));
        b = W'($urandom_range(0, (1 << W) - 1));
      end
      @(posedge clk); #1;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic check_result(input string tag, input int nbusy, input int exp_busy);
    chk({tag, "_busy_cycles"}, nbusy, exp_busy);
    chk({tag, "_q"}, quotient, exp_q);
    chk({tag, "_r"}, remainder, exp_r);
    chk({tag, "_z"}, div_by_zero, exp_z);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input bit scramble);
    int nb;
    logic [W-1:0] pq, pr;
    logic pz;
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(scramble, nb);
    pq = exp_q; pr = exp_r; pz = exp_z;
    model(ai, bi);
    check_result(tag, nb, (bi == 0) ? 0 : W);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    if (pq == exp_q && pr == exp_r && pz == exp_z) chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int nb;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_by_zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("d13_4", 4'd13, 4'd4, 1'b0);
    do_op("d15_1", 4'd15, 4'd1, 1'b0);
    do_op("d3_9", 4'd3, 4'd9, 1'b0);
    do_op("d7_0", 4'd7, 4'd0, 1'b0);

    // Second start and operand changes while busy must not disturb the division in flight.
    a = 4'd13; b = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    chk("ign_busy0", busy, 1);
    a = 4'd6; b = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    chk("ign_busy1", busy, 1);
    a = 4'd1; b = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b1, nb);
    model(4'd13, 4'd4);
    check_result("ign", nb + 2, W);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("ign_no_done", done, 0);
      chk("ign_no_busy", busy, 0);
    end

    // Start held high: back-to-back divisions.
    a = 4'd9; b = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      wait_done(1'b0, nb);
      model(4'd9, 4'd2);
      check_result("b2b", nb, W);
      if (k == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_end", done, 0);

    // Asynchronous reset in the second CALC cycle.
    a = 4'd13; b = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("arst_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_z", div_by_zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q = '0; exp_r = '0; exp_z = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("arst_no_done", done, 0);
      @(posedge clk); #1;
    end
    do_op("d10_3", 4'd10, 4'd3, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = (i % 5 == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
      do_op("rand", ra, rb, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
